// File: rtl/dmem_bus_bridge_pkg.sv
// Shared parameters, state encoding and helpers for the data-memory bus bridge.
package dmem_bus_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned        DMEM_TIMEOUT_CYCLES = 256;
  localparam logic [DATA_W-1:0]  DMEM_ERR_FILL       = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_SETUP = 2'd2,
    WR_WAIT  = 2'd3
  } bridge_state_e;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Simple request/acknowledge memory bus between the bridge and the memory system.
interface dmem_bus_bridge_if;
  import dmem_bus_bridge_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [BE_W-1:0]   bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges the CPU M-stage data access onto a req/ack bus, with stall,
// read-data hold and an optional access timeout.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = DMEM_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0] ERR_FILL       = DMEM_ERR_FILL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Mem_EarlyStrobe,
  input  logic [ADDR_W-1:0] Mem_EarlyAddress,
  input  logic              Mem_EarlyWrite,
  input  logic              Mem_Write,
  input  logic [DATA_W-1:0] Mem_WriteData,
  input  logic [BE_W-1:0]   Mem_ByteSelect,
  output logic              Mem_Stall,
  output logic [DATA_W-1:0] Mem_ReadData,
  output logic              Mem_BusError,
  dmem_bus_bridge_if.master bus
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(0);

  bridge_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic waiting_c;
  logic timeout_c;
  logic accept_c;

  // Waiting on the bus and timeout detection for the current cycle.
  always_comb begin
    waiting_c = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    timeout_c = waiting_c && !bus.bus_ack && (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end

  // Next-state and next register values; a new access is taken whenever the current one completes.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wr_addr_d = wr_addr_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;

    case (state_q)
      IDLE: begin
        accept_c = 1'b1;
      end
      RD_WAIT: begin
        if (bus.bus_ack) begin
          req_d    = 1'b0;
          rdata_d  = bus.bus_rdata;
          state_d  = IDLE;
          accept_c = 1'b1;
        end else if (timeout_c) begin
          req_d    = 1'b0;
          rdata_d  = ERR_FILL;
          err_d    = 1'b1;
          state_d  = IDLE;
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_SETUP: begin
        if (Mem_Write && (Mem_ByteSelect != '0)) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wr_addr_q;
          be_d    = Mem_ByteSelect;
          wdata_d = Mem_WriteData;
          cnt_d   = CNT_W'(0);
          state_d = WR_WAIT;
        end else begin
          state_d  = IDLE;
          accept_c = 1'b1;
        end
      end
      WR_WAIT: begin
        if (bus.bus_ack) begin
          req_d    = 1'b0;
          state_d  = IDLE;
          accept_c = 1'b1;
        end else if (timeout_c) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (accept_c && Mem_EarlyStrobe) begin
      if (Mem_EarlyWrite) begin
        state_d   = WR_SETUP;
        wr_addr_d = word_addr(Mem_EarlyAddress);
      end else begin
        state_d = RD_WAIT;
        req_d   = 1'b1;
        we_d    = 1'b0;
        be_d    = {BE_W{1'b1}};
        addr_d  = word_addr(Mem_EarlyAddress);
        cnt_d   = CNT_W'(0);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wr_addr_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wr_addr_q <= wr_addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stall and read-data bypass are combinational so a zero-wait read costs no stall.
  assign Mem_Stall    = (state_q == WR_SETUP) || (waiting_c && !bus.bus_ack && !timeout_c);
  assign Mem_ReadData = ((state_q == RD_WAIT) && bus.bus_ack) ? bus.bus_rdata : rdata_q;
  assign Mem_BusError = err_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a default-timeout instance and a TIMEOUT_CYCLES=4 instance.
module tb_dmem_bus_bridge;

  logic        clock;
  logic        reset;
  logic        strobe, strobe_t;
  logic [31:0] early_addr;
  logic        early_write;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bs;

  logic        stall0, err0, stall_t, err_t;
  logic [31:0] rdata0, rdata_t;

  int total = 0;
  int bad   = 0;

  dmem_bus_bridge_if bus0 ();
  dmem_bus_bridge_if bus_t ();

  dmem_bus_bridge dut (
    .clock            (clock),
    .reset            (reset),
    .Mem_EarlyStrobe  (strobe),
    .Mem_EarlyAddress (early_addr),
    .Mem_EarlyWrite   (early_write),
    .Mem_Write        (mem_write),
    .Mem_WriteData    (mem_wdata),
    .Mem_ByteSelect   (mem_bs),
    .Mem_Stall        (stall0),
    .Mem_ReadData     (rdata0),
    .Mem_BusError     (err0),
    .bus              (bus0)
  );

  dmem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut_t (
    .clock            (clock),
    .reset            (reset),
    .Mem_EarlyStrobe  (strobe_t),
    .Mem_EarlyAddress (early_addr),
    .Mem_EarlyWrite   (early_write),
    .Mem_Write        (mem_write),
    .Mem_WriteData    (mem_wdata),
    .Mem_ByteSelect   (mem_bs),
    .Mem_Stall        (stall_t),
    .Mem_ReadData     (rdata_t),
    .Mem_BusError     (err_t),
    .bus              (bus_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A new strobe must not be issued while a bus access is still waiting for ack.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(strobe && bus0.bus_req && !bus0.bus_ack))
        else $error("protocol violation: strobe during pending access");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int stall_cnt;
    int hs_cnt;
    int err_cnt;
    int first_rel;

    reset       = 1'b1;
    strobe      = 1'b0;
    strobe_t    = 1'b0;
    early_addr  = '0;
    early_write = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    mem_bs      = '0;
    bus0.bus_ack    = 1'b0;
    bus0.bus_rdata  = '0;
    bus_t.bus_ack   = 1'b0;
    bus_t.bus_rdata = '0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_req",   32'(bus0.bus_req), 32'd0);
    check("rst_we",    32'(bus0.bus_we), 32'd0);
    check("rst_addr",  bus0.bus_addr, 32'h0);
    check("rst_be",    32'(bus0.bus_be), 32'h0);
    check("rst_wdata", bus0.bus_wdata, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_err",   32'(err0), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Zero-wait read of 0x1004
    @(negedge clock);
    strobe = 1'b1; early_addr = 32'h0000_1004; early_write = 1'b0;
    #1 check("rd0_idle_stall", 32'(stall0), 32'd0);
    @(negedge clock);
    strobe = 1'b0;
    bus0.bus_ack = 1'b1; bus0.bus_rdata = 32'h1234_5678;
    #1;
    check("rd0_req",   32'(bus0.bus_req), 32'd1);
    check("rd0_we",    32'(bus0.bus_we), 32'd0);
    check("rd0_be",    32'(bus0.bus_be), 32'hF);
    check("rd0_addr",  bus0.bus_addr, 32'h0000_1004);
    check("rd0_stall", 32'(stall0), 32'd0);
    check("rd0_bypass", rdata0, 32'h1234_5678);
    @(negedge clock);
    bus0.bus_ack = 1'b0; bus0.bus_rdata = '0;
    #1;
    check("rd0_req_drop", 32'(bus0.bus_req), 32'd0);
    check("rd0_hold",     rdata0, 32'h1234_5678);
    check("rd0_stall_after", 32'(stall0), 32'd0);

    // Write to 0x2002, lanes 1:0, ack in the fourth wait cycle
    @(negedge clock);
    strobe = 1'b1; early_addr = 32'h0000_2002; early_write = 1'b1;
    #1 check("wr_idle_stall", 32'(stall0), 32'd0);
    @(negedge clock);
    strobe = 1'b0; early_write = 1'b0;
    mem_write = 1'b1; mem_wdata = 32'h0000_ABCD; mem_bs = 4'b0011;
    #1;
    stall_cnt = int'(stall0);
    hs_cnt = 0;
    check("wr_setup_noreq", 32'(bus0.bus_req), 32'd0);
    @(negedge clock);
    mem_write = 1'b0; mem_wdata = '0; mem_bs = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      bus0.bus_ack = (i == 3);
      #1;
      if (i == 0) begin
        check("wr_req",   32'(bus0.bus_req), 32'd1);
        check("wr_we",    32'(bus0.bus_we), 32'd1);
        check("wr_addr",  bus0.bus_addr, 32'h0000_2000);
        check("wr_be",    32'(bus0.bus_be), 32'h3);
        check("wr_wdata", bus0.bus_wdata, 32'h0000_ABCD);
      end
      stall_cnt += int'(stall0);
      if (bus0.bus_req && bus0.bus_ack) hs_cnt++;
    end
    @(negedge clock);
    bus0.bus_ack = 1'b0;
    #1;
    check("wr_req_drop",  32'(bus0.bus_req), 32'd0);
    check("wr_stall_end", 32'(stall0), 32'd0);
    check("wr_stall_cnt", 32'(stall_cnt), 32'd4);
    check("wr_bus_cycles", 32'(hs_cnt), 32'd1);
    check("wr_rdata_kept", rdata0, 32'h1234_5678);

    // Store cancelled in WR_SETUP
    @(negedge clock);
    strobe = 1'b1; early_addr = 32'h0000_3000; early_write = 1'b1;
    @(negedge clock);
    strobe = 1'b0; early_write = 1'b0; mem_write = 1'b0; mem_bs = 4'hF;
    #1;
    stall_cnt = int'(stall0);
    check("wrx_noreq", 32'(bus0.bus_req), 32'd0);
    @(negedge clock);
    mem_bs = '0;
    #1;
    stall_cnt += int'(stall0);
    check("wrx_noreq2",    32'(bus0.bus_req), 32'd0);
    check("wrx_stall_cnt", 32'(stall_cnt), 32'd1);

    // Ack while idle is ignored
    @(negedge clock);
    bus0.bus_ack = 1'b1; bus0.bus_rdata = 32'h1111_1111;
    #1 check("idle_ack_rdata", rdata0, 32'h1234_5678);
    @(negedge clock);
    bus0.bus_ack = 1'b0; bus0.bus_rdata = '0;
    #1;
    check("idle_ack_latch", rdata0, 32'h1234_5678);
    check("idle_ack_req",   32'(bus0.bus_req), 32'd0);

    // Read ack coincides with a new write strobe
    @(negedge clock);
    strobe = 1'b1; early_addr = 32'h0000_4008; early_write = 1'b0;
    @(negedge clock);
    bus0.bus_ack = 1'b1; bus0.bus_rdata = 32'hCAFE_F00D;
    strobe = 1'b1; early_addr = 32'h0000_5000; early_write = 1'b1;
    #1;
    check("b2b_rd_stall", 32'(stall0), 32'd0);
    check("b2b_rd_data",  rdata0, 32'hCAFE_F00D);
    @(negedge clock);
    strobe = 1'b0; early_write = 1'b0;
    bus0.bus_ack = 1'b0; bus0.bus_rdata = '0; mem_write = 1'b0;
    #1;
    check("b2b_wr_setup", 32'(stall0), 32'd1);
    check("b2b_noreq",    32'(bus0.bus_req), 32'd0);
    check("b2b_hold",     rdata0, 32'hCAFE_F00D);
    @(negedge clock);
    #1 check("b2b_done", 32'(stall0), 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    @(negedge clock);
    strobe_t = 1'b1; early_addr = 32'h0000_6000; early_write = 1'b0;
    @(negedge clock);
    strobe_t = 1'b0;
    stall_cnt = 0; err_cnt = 0; first_rel = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (i == 0) begin
        check("to_req",  32'(bus_t.bus_req), 32'd1);
        check("to_addr", bus_t.bus_addr, 32'h0000_6000);
      end
      if (i == 4) begin
        check("to_err_pulse", 32'(err_t), 32'd1);
        check("to_fill",      rdata_t, 32'hDEAD_BEEF);
        check("to_req_drop",  32'(bus_t.bus_req), 32'd0);
      end
      stall_cnt += int'(stall_t);
      if (!stall_t && first_rel < 0) first_rel = i;
      err_cnt += int'(err_t);
    end
    check("to_stall_cnt", 32'(stall_cnt), 32'd3);
    check("to_release",   32'(first_rel), 32'd3);
    check("to_err_cnt",   32'(err_cnt), 32'd1);
    check("to_fill_hold", rdata_t, 32'hDEAD_BEEF);

    // Reset in RD_WAIT, then a late ack
    @(negedge clock);
    strobe = 1'b1; early_addr = 32'h0000_7000; early_write = 1'b0;
    @(negedge clock);
    strobe = 1'b0;
    #1 check("rr_req", 32'(bus0.bus_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rr_req_drop", 32'(bus0.bus_req), 32'd0);
    check("rr_stall",    32'(stall0), 32'd0);
    check("rr_rdata",    rdata0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    bus0.bus_ack = 1'b1; bus0.bus_rdata = 32'h9999_9999;
    #1;
    check("rr_late_stall", 32'(stall0), 32'd0);
    check("rr_late_rdata", rdata0, 32'h0);
    check("rr_late_req",   32'(bus0.bus_req), 32'd0);
    @(negedge clock);
    bus0.bus_ack = 1'b0; bus0.bus_rdata = '0;
    #1;
    check("rr_after_rdata", rdata0, 32'h0);
    check("rr_after_err",   32'(err0), 32'd0);
    check("rr_after_req",   32'(bus0.bus_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
